// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: widths, polarity constants
// and the responder FSM state encoding.
package data_mem_responder_pkg;

  localparam int DATA_MEM_NUM_LOG2 = 10;
  localparam int DATA_MEM_NUM      = 1 << DATA_MEM_NUM_LOG2;
  localparam int DATA_W            = 32;

  localparam logic              RST_ENABLE   = 1'b1;
  localparam logic              WRITE_ENABLE = 1'b1;
  localparam logic [DATA_W-1:0] ZERO_WORD    = '0;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10,
    DMEM_ERR  = 2'b11
  } dmem_state_e;

endpackage

// File: rtl/data_mem_responder_array.sv
// Four byte-wide synchronous RAM banks with per-lane write enable and a
// registered read port that holds its value until the next read.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DATA_MEM_NUM_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Lane b holds bits [8b+7:8b]; lane 3 is big-endian byte offset 0.
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we[b] == WRITE_ENABLE) begin
        bank[addr] <= wdata[8*b +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
        rd_q <= '0;
      end else if (re) begin
        rd_q <= bank[addr];
      end
    end

    assign rdata[8*b +: 8] = rd_q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store target for the CPU data port: one request at a time, fixed wait
// states, then a one-cycle ack (with err for misaligned/out-of-range accesses).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        capture;
  logic        commit;
  logic        bad_addr;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            sel_q;
  logic [31:0]           data_q;

  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [3:0]            op_sel;
  logic [31:0]           op_data;
  logic [3:0]            mem_we;
  logic                  mem_re;

  assign bad_addr = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_WIDTH+2] != '0);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state  <= DMEM_IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        we_q   <= we_i;
        addr_q <= addr_i[ADDR_WIDTH+1:2];
        sel_q  <= sel_i;
        data_q <= data_i;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    commit  = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (req_i) begin
          capture = 1'b1;
          if (bad_addr) begin
            state_n = DMEM_ERR;
          end else if (WAIT_CYCLES == 0) begin
            state_n = DMEM_RESP;
            commit  = 1'b1;
          end else begin
            state_n = DMEM_WAIT;
            cnt_n   = WAIT_LOAD;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = DMEM_RESP;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DMEM_RESP: state_n = DMEM_IDLE;
      DMEM_ERR:  state_n = DMEM_IDLE;
      default:   state_n = DMEM_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, before
  // the capture registers are loaded, so the live inputs are used instead.
  always_comb begin
    if (state == DMEM_IDLE) begin
      op_we   = we_i;
      op_addr = addr_i[ADDR_WIDTH+1:2];
      op_sel  = sel_i;
      op_data = data_i;
    end else begin
      op_we   = we_q;
      op_addr = addr_q;
      op_sel  = sel_q;
      op_data = data_q;
    end
  end

  // Reset on the commit edge suppresses the memory side effects.
  always_comb begin
    mem_we = '0;
    mem_re = 1'b0;
    if (commit && (rst != RST_ENABLE)) begin
      if (op_we == WRITE_ENABLE) begin
        mem_we = op_sel;
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (op_addr),
    .wdata(op_data),
    .rdata(data_o)
  );

  assign ack_o  = (state == DMEM_RESP) || (state == DMEM_ERR);
  assign err_o  = (state == DMEM_ERR);
  assign busy_o = (state != DMEM_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with the default 1024-word, 2-wait configuration.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic        err_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(
    .ADDR_WIDTH (10),
    .WAIT_CYCLES(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i),
    .we_i  (we_i),
    .addr_i(addr_i),
    .sel_i (sel_i),
    .data_i(data_i),
    .data_o(data_o),
    .ack_o (ack_o),
    .err_o (err_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_data);
    int lat;
    req_i  = 1'b1;
    we_i   = we;
    addr_i = addr;
    sel_i  = sel;
    data_i = wdata;
    @(posedge clk);
    #1 req_i = 1'b0;
    lat = 0;
    while (lat < 16) begin
      @(negedge clk);
      lat++;
      if (ack_o === 1'b1) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ack"}, {31'd0, ack_o}, 32'd1);
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    check({tag, "_data"}, data_o, exp_data);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, ack_o}, 32'd0);
  endtask

  initial begin
    int acks;
    rst    = 1'b1;
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = 32'h0000_0010;
    sel_i  = 4'hF;
    data_i = 32'h5555_5555;

    repeat (3) begin
      @(negedge clk);
      check("rst_ack", {31'd0, ack_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_data", data_o, 32'h0000_0000);
    end
    rst   = 1'b0;
    req_i = 1'b0;

    // Store then load
    access("st10", 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0000);
    access("ld10", 1'b0, 32'h0000_0010, 4'h0, 32'h0,         3, 1'b0, 32'hDEAD_BEEF);

    // Byte lanes
    access("st_b0", 1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA, 3, 1'b0, 32'hDEAD_BEEF);
    access("st_b3", 1'b1, 32'h0000_0010, 4'b1000, 32'h1100_0000, 3, 1'b0, 32'hDEAD_BEEF);
    access("ld_lanes", 1'b0, 32'h0000_0010, 4'h0, 32'h0,         3, 1'b0, 32'h11AD_BEAA);

    // Errors
    access("st00", 1'b1, 32'h0000_0000, 4'hF, 32'h0123_4567, 3, 1'b0, 32'h11AD_BEAA);
    access("err_mis", 1'b0, 32'h0000_0012, 4'h0, 32'h0,         1, 1'b1, 32'h11AD_BEAA);
    access("err_oor", 1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, 1, 1'b1, 32'h11AD_BEAA);
    access("ld00", 1'b0, 32'h0000_0000, 4'h0, 32'h0,            3, 1'b0, 32'h0123_4567);

    // Dropped request while in WAIT
    access("st20", 1'b1, 32'h0000_0020, 4'hF, 32'h55AA_55AA, 3, 1'b0, 32'h0123_4567);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = 32'h0000_0024;
    sel_i  = 4'hF;
    data_i = 32'h0000_0000;
    @(posedge clk);
    #1;
    addr_i = 32'h0000_0020;
    data_i = 32'h1234_5678;
    @(posedge clk);
    @(posedge clk);
    #1 req_i = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_o === 1'b1) acks++;
    end
    check("drop_acks", 32'(acks), 32'd1);
    access("ld20", 1'b0, 32'h0000_0020, 4'h0, 32'h0, 3, 1'b0, 32'h55AA_55AA);

    // Reset on the commit edge of a store
    access("st30", 1'b1, 32'h0000_0030, 4'hF, 32'hAAAA_5555, 3, 1'b0, 32'h55AA_55AA);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = 32'h0000_0030;
    sel_i  = 4'hF;
    data_i = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", {31'd0, ack_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_data", data_o, 32'h0000_0000);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ack2", {31'd0, ack_o}, 32'd0);
    access("ld30", 1'b0, 32'h0000_0030, 4'h0, 32'h0, 3, 1'b0, 32'hAAAA_5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
